// File: rtl/timer_mch.sv
// N_CH-channel up/down timer behind one 8-bit APB slave, shared 4-bit prescaler.
// Define TMR_IRQ_EN to build the TIER registers and the registered irq outputs.
module timer_mch #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [$clog2(N_CH)+3:0]   paddr,
  input  logic [7:0]                pwdata,
  output logic [7:0]                prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic [N_CH-1:0]           irq_ch,
  output logic                      irq
);
  localparam int AW  = $clog2(N_CH) + 4;
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int NB  = CNT_W / 8;
  localparam logic [CHW:0] NCH_L = (CHW+1)'(N_CH);

  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [3:0] off;
    logic [7:0] wdata;
  } req_t;

  logic [3:0]            psc_q;
  logic [CHW-1:0]        ch_idx;
  logic                  acc, ch_ok, off_ok;
  req_t                  req;
  logic [N_CH-1:0]       ch_hit;
  logic [N_CH-1:0][7:0]  ch_rdata;

  if (N_CH > 1) begin : g_idx
    assign ch_idx = paddr[AW-1:4];
  end else begin : g_idx1
    assign ch_idx = '0;
  end

  assign acc       = psel & penable;
  assign ch_ok     = {1'b0, ch_idx} < NCH_L;
  assign off_ok    = paddr[3:0] <= 4'hA;
  assign req.wr    = acc & pwrite & ch_ok & off_ok;
  assign req.rd    = acc & ~pwrite & ch_ok & off_ok;
  assign req.off   = paddr[3:0];
  assign req.wdata = pwdata;

  assign pready  = 1'b1;
  assign pslverr = acc & ~(ch_ok & off_ok);
  assign irq     = |irq_ch;

  always_comb begin
    prdata = '0;
    if (req.rd)
      for (int i = 0; i < N_CH; i++)
        if (ch_hit[i]) prdata = ch_rdata[i];
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) psc_q <= '0;
    else        psc_q <= psc_q + 4'd1;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] tdr_q, tdr_d, cnt_q, cnt_d, shd_q, cnt_view;
    logic             ld_q, arl_q, dw_q, en_q;
    logic [1:0]       cs_q;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             wr, tick;
    logic [3:0]       msk;
    logic [7:0]       tier, rd_c;

    assign ch_hit[i] = (ch_idx == CHW'(i));
    assign wr        = req.wr & ch_hit[i];
    // clk_sel picks how many low prescaler bits must be all ones
    assign msk       = 4'hF >> (2'd3 - cs_q);
    assign tick      = (psc_q & msk) == msk;

    always_comb begin
      tdr_d = tdr_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      udf_d = udf_q;
      for (int b = 0; b < NB; b++)
        if (wr && req.off == 4'(b)) tdr_d[b*8 +: 8] = req.wdata;
      if (wr && req.off == 4'h9) begin
        ovf_d = ovf_q & req.wdata[0];
        udf_d = udf_q & req.wdata[1];
      end
      // hardware set overrides a same-cycle software clear
      if (ld_q) begin
        cnt_d = tdr_q;
      end else if (en_q && tick) begin
        if (!dw_q) begin
          if (&cnt_q) begin
            ovf_d = 1'b1;
            cnt_d = arl_q ? tdr_q : '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          if (cnt_q == '0) begin
            udf_d = 1'b1;
            cnt_d = arl_q ? tdr_q : '1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
    end

    always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
        tdr_q <= '0;
        cnt_q <= '0;
        shd_q <= '0;
        ld_q  <= 1'b0;
        arl_q <= 1'b0;
        dw_q  <= 1'b0;
        en_q  <= 1'b0;
        cs_q  <= '0;
        ovf_q <= 1'b0;
        udf_q <= 1'b0;
      end else begin
        tdr_q <= tdr_d;
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
        udf_q <= udf_d;
        if (wr && req.off == 4'h8) begin
          {ld_q, arl_q, dw_q, en_q} <= req.wdata[7:4];
          cs_q <= req.wdata[1:0];
        end
        // low-byte read freezes the upper bytes for the follow-up reads
        if (req.rd && ch_hit[i] && req.off == 4'h4) shd_q <= cnt_q;
      end
    end

`ifdef TMR_IRQ_EN
    logic oie_q, uie_q, irq_q;
    always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
        oie_q <= 1'b0;
        uie_q <= 1'b0;
        irq_q <= 1'b0;
      end else begin
        if (wr && req.off == 4'hA) {uie_q, oie_q} <= req.wdata[1:0];
        irq_q <= (ovf_q & oie_q) | (udf_q & uie_q);
      end
    end
    assign tier      = {6'b0, uie_q, oie_q};
    assign irq_ch[i] = irq_q;
`else
    assign tier      = 8'h00;
    assign irq_ch[i] = 1'b0;
`endif

    assign cnt_view = (req.off == 4'h4) ? cnt_q : shd_q;

    always_comb begin
      rd_c = '0;
      case (req.off)
        4'h0, 4'h1, 4'h2, 4'h3:
          for (int b = 0; b < NB; b++)
            if (req.off == 4'(b)) rd_c = tdr_q[b*8 +: 8];
        4'h4, 4'h5, 4'h6, 4'h7:
          for (int b = 0; b < NB; b++)
            if (req.off == 4'(4 + b)) rd_c = cnt_view[b*8 +: 8];
        4'h8:    rd_c = {ld_q, arl_q, dw_q, en_q, 2'b00, cs_q};
        4'h9:    rd_c = {6'b0, udf_q, ovf_q};
        4'hA:    rd_c = tier;
        default: rd_c = '0;
      endcase
    end
    assign ch_rdata[i] = rd_c;
  end

endmodule
